// File: rtl/id_stage_hz.sv
// Instruction-decode stage: field decode, sign-extended immediate, register file with WB port,
// forwarding selects and load-use interlock. Optional macro: ID_WB_BYPASS_EN (WB-to-read bypass).
module id_stage_hz #(
   parameter int         DATA_W  = 32,
   parameter int         NREG    = 32,
   parameter logic [5:0] OP_LDW  = 6'h23,
   parameter logic [5:0] OP_SDW  = 6'h2B,
   parameter logic [5:0] OP_BEQ  = 6'h04,
   parameter logic [5:0] OP_JUMP = 6'h02,
   localparam int        REG_AW  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_in,
   input  logic              instr_valid,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              id_stall,
   output logic              valid_out,
   output logic [5:0]        opcode_out,
   output logic [REG_AW-1:0] rwd_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] val_rs_out,
   output logic [DATA_W-1:0] val_rt_out,
   output logic [1:0]        rs_fwd,
   output logic [1:0]        rt_fwd
);

   logic [DATA_W-1:0] r_rf [NREG];

   logic              r_valid;
   logic [5:0]        r_opcode;
   logic [REG_AW-1:0] r_rwd;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_val_rs;
   logic [DATA_W-1:0] r_val_rt;
   logic [1:0]        r_rs_fwd;
   logic [1:0]        r_rt_fwd;

   // Destination history of the instructions now in EX (h1), MEM (h2) and WB (h3).
   logic [REG_AW-1:0] r_h1;
   logic [REG_AW-1:0] r_h2;
   logic [REG_AW-1:0] r_h3;
   logic              r_h1_ld;

   logic [5:0]                   w_op;
   logic                         w_is_ldw;
   logic                         w_is_sdw;
   logic                         w_is_beq;
   logic                         w_is_jmp;
   logic [REG_AW-1:0]            w_dest;
   logic [DATA_W-1:0]            w_imm;
   logic [1:0][REG_AW-1:0]       w_src;
   logic [1:0]                   w_use;
   logic [1:0][DATA_W-1:0]       w_rd;
   logic [1:0][1:0]              w_fwd;
   logic [1:0]                   w_ld_hit;
   logic                         w_stall_raw;
   logic                         w_issue;

   assign w_op     = instr_in[31:26];
   assign w_is_ldw = (w_op == OP_LDW);
   assign w_is_sdw = (w_op == OP_SDW);
   assign w_is_beq = (w_op == OP_BEQ);
   assign w_is_jmp = (w_op == OP_JUMP);

   // Source 0 is rs, source 1 is rt; rt moves to [25:21] for formats that have no destination there.
   assign w_src[0] = instr_in[16 +: REG_AW];
   assign w_src[1] = (w_is_sdw || w_is_beq || w_is_ldw) ? instr_in[21 +: REG_AW]
                                                         : instr_in[11 +: REG_AW];
   assign w_use[0] = !w_is_jmp;
   assign w_use[1] = !w_is_jmp && !w_is_ldw;
   assign w_dest   = (w_is_sdw || w_is_beq || w_is_jmp) ? '0 : instr_in[21 +: REG_AW];
   assign w_imm    = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic [DATA_W-1:0] w_rd_g;
         logic [1:0]        w_fwd_g;

         always_comb begin
            w_rd_g = '0;
            if (w_src[gi] != '0) begin
               w_rd_g = r_rf[w_src[gi]];
`ifdef ID_WB_BYPASS_EN
               if (wb_we && (wb_addr == w_src[gi]))
                  w_rd_g = wb_data;
`endif
            end
         end

         always_comb begin
            w_fwd_g = 2'd0;
            if (w_use[gi] && (w_src[gi] != '0)) begin
               if (w_src[gi] == r_h1)
                  w_fwd_g = 2'd1;
               else if (w_src[gi] == r_h2)
                  w_fwd_g = 2'd2;
`ifndef ID_WB_BYPASS_EN
               else if (w_src[gi] == r_h3)
                  w_fwd_g = 2'd3;
`endif
            end
         end

         assign w_rd[gi]     = w_rd_g;
         assign w_fwd[gi]    = w_fwd_g;
         assign w_ld_hit[gi] = r_h1_ld && w_use[gi] && (w_src[gi] != '0) && (w_src[gi] == r_h1);
      end
   endgenerate

   assign w_stall_raw = instr_valid && !flush && (|w_ld_hit);
   assign w_issue     = instr_valid && !flush && !w_stall_raw;
   assign id_stall    = rst_n && w_stall_raw;

   // Register file keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (wb_we && (wb_addr != '0))
         r_rf[wb_addr] <= wb_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_opcode <= '0;
         r_rwd    <= '0;
         r_imm    <= '0;
         r_val_rs <= '0;
         r_val_rt <= '0;
         r_rs_fwd <= '0;
         r_rt_fwd <= '0;
         r_h1     <= '0;
         r_h2     <= '0;
         r_h3     <= '0;
         r_h1_ld  <= 1'b0;
      end else begin
         r_h2 <= r_h1;
         r_h3 <= r_h2;
         if (w_issue) begin
            r_valid  <= 1'b1;
            r_opcode <= w_op;
            r_rwd    <= w_dest;
            r_imm    <= w_imm;
            r_val_rs <= w_rd[0];
            r_val_rt <= w_rd[1];
            r_rs_fwd <= w_fwd[0];
            r_rt_fwd <= w_fwd[1];
            r_h1     <= w_dest;
            r_h1_ld  <= w_is_ldw;
         end else begin
            r_valid  <= 1'b0;
            r_opcode <= '0;
            r_rwd    <= '0;
            r_imm    <= '0;
            r_val_rs <= '0;
            r_val_rt <= '0;
            r_rs_fwd <= '0;
            r_rt_fwd <= '0;
            r_h1     <= '0;
            r_h1_ld  <= 1'b0;
         end
      end
   end

   assign valid_out  = r_valid;
   assign opcode_out = r_opcode;
   assign rwd_out    = r_rwd;
   assign imm_out    = r_imm;
   assign val_rs_out = r_val_rs;
   assign val_rt_out = r_val_rt;
   assign rs_fwd     = r_rs_fwd;
   assign rt_fwd     = r_rt_fwd;

endmodule

// File: tb/tb_id_stage_hz.sv
// Table-driven bench for id_stage_hz: preloads r1..r7, then walks a directed vector sequence
// covering reset, forwarding distances, load-use stall, flush, r0 handling and WB collision.
module tb_id_stage_hz;

   localparam logic [5:0] ADD = 6'h20;
   localparam logic [5:0] SUB = 6'h22;
   localparam logic [5:0] LDW = 6'h23;
   localparam logic [5:0] SDW = 6'h2B;
   localparam logic [5:0] BEQ = 6'h04;
   localparam logic [5:0] JMP = 6'h02;

`ifdef ID_WB_BYPASS_EN
   localparam logic [1:0]  F3     = 2'd0;
   localparam logic [31:0] BYP_R7 = 32'h0000_DEAD;
`else
   localparam logic [1:0]  F3     = 2'd3;
   localparam logic [31:0] BYP_R7 = 32'h0000_0107;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        id_stall;
   logic        valid_out;
   logic [5:0]  opcode_out;
   logic [4:0]  rwd_out;
   logic [31:0] imm_out;
   logic [31:0] val_rs_out;
   logic [31:0] val_rt_out;
   logic [1:0]  rs_fwd;
   logic [1:0]  rt_fwd;

   id_stage_hz dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_in   (instr_in),
      .instr_valid(instr_valid),
      .flush      (flush),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .id_stall   (id_stall),
      .valid_out  (valid_out),
      .opcode_out (opcode_out),
      .rwd_out    (rwd_out),
      .imm_out    (imm_out),
      .val_rs_out (val_rs_out),
      .val_rt_out (val_rt_out),
      .rs_fwd     (rs_fwd),
      .rt_fwd     (rt_fwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        valid;
      logic        flush;
      logic [31:0] instr;
      logic        wbwe;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        stall;
      logic        vo;
      logic [5:0]  op;
      logic [4:0]  rwd;
      logic [31:0] imm;
      logic [31:0] vrs;
      logic [31:0] vrt;
      logic [1:0]  rsf;
      logic [1:0]  rtf;
   } vec_t;

   localparam int NV = 21;
   vec_t tv [NV];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] f25,
                                       input logic [4:0] f20, input logic [15:0] imm);
      return {op, f25, f20, imm};
   endfunction

   function automatic vec_t mkv(input logic r, input logic v, input logic f, input logic [31:0] in,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic st, input logic vo, input logic [5:0] op,
                                input logic [4:0] rwd, input logic [31:0] imm,
                                input logic [31:0] vrs, input logic [31:0] vrt,
                                input logic [1:0] rsf, input logic [1:0] rtf);
      vec_t x;
      x.rst_n = r;  x.valid = v;  x.flush = f;  x.instr = in;
      x.wbwe = we;  x.wba = wa;   x.wbd = wd;
      x.stall = st; x.vo = vo;    x.op = op;    x.rwd = rwd; x.imm = imm;
      x.vrs = vrs;  x.vrt = vrt;  x.rsf = rsf;  x.rtf = rtf;
      return x;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL v%0d %s got=%h exp=%h", idx, name, got, exp);
      else
         n_pass++;
   endtask

   initial begin
      // Reset held two cycles with a real instruction presented.
      tv[0]  = mkv(0,1,0, ins(ADD,3,1,16'h1000), 0,0,0, 0,0,6'h00,0,0,0,0,0,0);
      tv[1]  = mkv(0,1,0, ins(ADD,3,1,16'h1000), 0,0,0, 0,0,6'h00,0,0,0,0,0,0);
      tv[2]  = mkv(1,1,0, ins(ADD,3,1,16'h1000), 0,0,0, 0,1,ADD,3,32'h1000,32'h101,32'h102,0,0);
      tv[3]  = mkv(1,1,0, ins(ADD,5,6,16'h3800), 0,0,0, 0,1,ADD,5,32'h3800,32'h106,32'h107,0,0);
      tv[4]  = mkv(1,1,0, ins(SUB,6,5,16'h1800), 0,0,0, 0,1,SUB,6,32'h1800,32'h105,32'h103,1,2);
      tv[5]  = mkv(1,1,0, ins(ADD,7,3,16'h2800), 0,0,0, 0,1,ADD,7,32'h2800,32'h103,32'h105,F3,2);
      tv[6]  = mkv(1,0,0, ins(ADD,1,1,16'h0800), 0,0,0, 0,0,6'h00,0,0,0,0,0,0);
      tv[7]  = mkv(1,1,0, ins(LDW,4,1,16'hFFF0), 0,0,0, 0,1,LDW,4,32'hFFFF_FFF0,32'h101,32'h104,0,0);
      // Load-use: one stall cycle with a bubble, then issue with MEM forwarding.
      tv[8]  = mkv(1,1,0, ins(ADD,2,4,16'h0800), 0,0,0, 1,0,6'h00,0,0,0,0,0,0);
      tv[9]  = mkv(1,1,0, ins(ADD,2,4,16'h0800), 0,0,0, 0,1,ADD,2,32'h0800,32'h104,32'h101,2,0);
      tv[10] = mkv(1,1,0, ins(LDW,5,2,16'h0004), 0,0,0, 0,1,LDW,5,32'h4,32'h102,32'h105,1,0);
      // Flush while a load-use hazard is present: no stall, bubble issued.
      tv[11] = mkv(1,1,1, ins(ADD,6,7,16'h2800), 0,0,0, 0,0,6'h00,0,0,0,0,0,0);
      tv[12] = mkv(1,1,0, ins(ADD,3,5,16'h1000), 0,0,0, 0,1,ADD,3,32'h1000,32'h105,32'h102,2,F3);
      tv[13] = mkv(1,1,0, ins(JMP,3,3,16'h1800), 0,0,0, 0,1,JMP,0,32'h1800,32'h103,32'h103,0,0);
      tv[14] = mkv(1,1,0, ins(SDW,0,0,16'h0010), 0,0,0, 0,1,SDW,0,32'h10,0,0,0,0);
      tv[15] = mkv(1,1,0, ins(BEQ,7,3,16'hFFFF), 0,0,0, 0,1,BEQ,0,32'hFFFF_FFFF,32'h103,32'h107,F3,0);
      // Write-back to r7 in the same cycle ID reads r7.
      tv[16] = mkv(1,1,0, ins(ADD,1,7,16'h3000), 1,7,32'hDEAD, 0,1,ADD,1,32'h3000,BYP_R7,32'h106,0,0);
      tv[17] = mkv(1,1,0, ins(ADD,2,7,16'h0000), 0,0,0, 0,1,ADD,2,32'h0,32'hDEAD,0,0,0);
      tv[18] = mkv(1,1,0, ins(LDW,3,0,16'h0000), 0,0,0, 0,1,LDW,3,32'h0,0,32'h103,0,0);
      // Reset while the dependent instruction would stall: stall masked, history cleared.
      tv[19] = mkv(0,1,0, ins(ADD,4,3,16'h0000), 0,0,0, 0,0,6'h00,0,0,0,0,0,0);
      tv[20] = mkv(1,1,0, ins(ADD,4,3,16'h0000), 0,0,0, 0,1,ADD,4,32'h0,32'h103,0,0,0);

      rst_n = 1'b1; instr_valid = 1'b0; flush = 1'b0; instr_in = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;

      // Preload r1..r7 = 0x100+i and attempt a write of 0x1234 to r0.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         wb_we   = 1'b1;
         wb_addr = 5'(i);
         wb_data = (i == 0) ? 32'h1234 : 32'h100 + 32'(i);
      end
      @(negedge clk);
      wb_we = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n       = tv[i].rst_n;
         instr_valid = tv[i].valid;
         flush       = tv[i].flush;
         instr_in    = tv[i].instr;
         wb_we       = tv[i].wbwe;
         wb_addr     = tv[i].wba;
         wb_data     = tv[i].wbd;
         #1;
         chk("id_stall", i, 32'(id_stall), 32'(tv[i].stall));
         @(posedge clk);
         #1;
         chk("valid_out",  i, 32'(valid_out),  32'(tv[i].vo));
         chk("opcode_out", i, 32'(opcode_out), 32'(tv[i].op));
         chk("rwd_out",    i, 32'(rwd_out),    32'(tv[i].rwd));
         chk("imm_out",    i, imm_out,         tv[i].imm);
         chk("val_rs_out", i, val_rs_out,      tv[i].vrs);
         chk("val_rt_out", i, val_rt_out,      tv[i].vrt);
         chk("rs_fwd",     i, 32'(rs_fwd),     32'(tv[i].rsf));
         chk("rt_fwd",     i, 32'(rt_fwd),     32'(tv[i].rtf));
         $display("v%0d instr=%h vld=%0d fl=%0d rst_n=%0d -> stall=%0d vo=%0d rwd=%0d rsf=%0d rtf=%0d",
                  i, tv[i].instr, tv[i].valid, tv[i].flush, tv[i].rst_n, tv[i].stall,
                  valid_out, rwd_out, rs_fwd, rt_fwd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
